uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- UART transmitter that drains the UART TX FIFO directly.
- Pops one word per frame whenever the FIFO reports non-empty, then serializes it LSB-first: start bit, DBIT data bits, optional parity bit, stop time.
- Timing comes from the shared baud-rate generator's oversampling tick (16 ticks per bit).
- Sits between the TX FIFO output (read data, empty flag, read strobe) and the device pin.

Parameters:
DBIT, 8, data bits per frame (5..9); must equal the FIFO word width B
SB_TICK, 16, ticks spent in stop state (16 = 1 stop bit, 24 = 1.5, 32 = 2)

Ports:
i_clk  input  1  system clock
i_reset  input  1  synchronous active-high reset
i_s_tick  input  1  one-clock-wide oversampling tick, 16 per bit period
i_empty  input  1  FIFO empty flag
i_rd_data  input  DBIT  FIFO head word, valid combinationally while i_empty=0
i_parity_en  input  1  1 = append parity bit
i_parity_odd  input  1  1 = odd parity, 0 = even
o_rd  output  1  one-cycle FIFO pop strobe
o_tx  output  1  serial line, idle high, registered
o_busy  output  1  high in every state except IDLE
o_done_tick  output  1  one-cycle pulse when the stop period completes

Behaviour:
- One clock, i_clk. Reset is synchronous and active-high on i_reset; all state updates on the rising edge.
- Reset values:
  - state=IDLE, o_tx=1, o_rd=0, o_busy=0, o_done_tick=0
  - tick counter s=0, bit counter n=0, shift register and parity accumulator 0
- Registers:
  - s: 4 bits wide enough for SB_TICK-1; clog2(SB_TICK) bits minimum.
  - n: clog2(DBIT) bits.
  - b: DBIT bits.
  - par: 1 bit.
  - par_en/par_odd: latched copies of the config inputs.
- o_rd is combinational: asserted exactly when state=IDLE and i_empty=0. It is never asserted in any other state, and never more than once per frame.
- IDLE:
  - o_tx=1.
  - If i_empty=0: b<=i_rd_data, latch i_parity_en/i_parity_odd, par<=0, s<=0, go START.
  - The FIFO is first-word-fall-through, so data is captured in the same cycle as the pop.
- START:
  - o_tx=0.
  - On i_s_tick: if s==15, then s<=0, n<=0, go DATA; else s<=s+1.
- DATA:
  - o_tx=b[0].
  - On i_s_tick with s==15: par<=par^b[0], b<=b>>1, s<=0.
    - If n==DBIT-1: go PARITY when par_en, else go STOP.
    - Otherwise n<=n+1.
  - On i_s_tick with s!=15: s<=s+1.
- PARITY:
  - o_tx = par ^ par_odd (even: XOR of data bits; odd: its inverse).
  - After 16 ticks go STOP with s<=0.
- STOP:
  - o_tx=1.
  - On i_s_tick with s==SB_TICK-1: o_done_tick=1 for that cycle, go IDLE.
- o_tx is registered from the next-state value, so the line changes on the clock edge at which the state/bit changes. First start-bit low appears one cycle after the o_rd cycle.
- Cycles without i_s_tick hold all counters.
- Ticks arriving in IDLE are ignored.
- Frame length is (1+DBIT+par_en)*16+SB_TICK ticks.
- Back-to-back frames:
  - After the STOP→IDLE edge, IDLE samples i_empty on the very next cycle.
  - Minimum gap between frames: SB_TICK ticks of high plus one clock.
- Config inputs changing mid-frame have no effect; the latched copy is used.
- i_rd_data changes while the FIFO is not being popped are ignored outside IDLE.
- Reset mid-frame:
  - Next edge returns to IDLE with o_tx=1; no o_done_tick.
  - The popped word is discarded (it is not re-read).
  - o_rd stays 0 during the reset cycle.
- Simultaneous reset and i_s_tick: reset wins.
- FIFO becoming empty mid-frame has no effect on the current frame.

Test Plan:
- Reset with the FIFO holding 0x55 → during i_reset=1: o_tx=1, o_rd=0. First cycle after release: o_rd=1 for exactly one cycle.
- DBIT=8, parity off, tick every 4 clocks, push 0x55 → o_tx sequence of 64-clock segments is 0 | 1,0,1,0,1,0,1,0 | 1. o_done_tick pulses once after 160 ticks; o_busy is high throughout.
- Parity even, send 0xA3 then 0x07 → parity bit is 0 for 0xA3 and 1 for 0x07. With i_parity_odd=1 both parity bits are inverted (1 and 0). Frame is 176 ticks.
- Push 3 bytes 0x01, 0x80, 0xFF back-to-back → exactly 3 o_rd pulses, each in the IDLE cycle right after the previous o_done_tick. Bytes arrive at the line in order with no extra idle beyond stop time.
- Assert i_reset during DATA bit 3 of 0x3C → o_tx=1 next cycle, no o_done_tick. The next queued byte starts a clean frame after reset drops.
- SB_TICK=32, toggle i_parity_en mid-frame → stop period lasts 32 ticks. The mid-frame toggle does not change the current frame; it applies only to the next frame.

Source files
------------

// File: rtl/uart_tx_if.sv
// ---------------------------------------------------------------------------
// uart_tx_if : FIFO read-side handshake between the UART TX FIFO and the
//              transmitter.
//   i_empty   : FIFO empty flag (driven by the FIFO)
//   i_rd_data : FIFO head word, first-word-fall-through (driven by the FIFO)
//   o_rd      : one-cycle pop strobe (driven by the transmitter)
// master = FIFO side, slave = transmitter side.
// ---------------------------------------------------------------------------
interface uart_tx_if #(
   parameter int DBIT = 8
);
   logic            i_empty;
   logic [DBIT-1:0] i_rd_data;
   logic            o_rd;

   modport master (output i_empty, output i_rd_data, input o_rd);
   modport slave  (input i_empty, input i_rd_data, output o_rd);
endinterface

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx : UART transmitter draining a first-word-fall-through TX FIFO.
//   Frame: start bit, DBIT data bits LSB first, optional parity bit, then
//   SB_TICK oversampling ticks of stop time. 16 ticks per bit.
// Ports:
//   i_clk        system clock
//   i_reset      synchronous active-high reset
//   i_s_tick     one-clock oversampling tick (16 per bit)
//   fifo         FIFO handshake (i_empty, i_rd_data in; o_rd out)
//   i_parity_en  1 = append parity bit (latched at pop)
//   i_parity_odd 1 = odd parity, 0 = even (latched at pop)
//   o_tx         serial line, idle high, registered
//   o_busy       high in every state except IDLE
//   o_done_tick  one-cycle pulse when the stop period completes
// ---------------------------------------------------------------------------
module uart_tx #(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16
) (
   input  logic      i_clk,
   input  logic      i_reset,
   input  logic      i_s_tick,
   uart_tx_if.slave  fifo,
   input  logic      i_parity_en,
   input  logic      i_parity_odd,
   output logic      o_tx,
   output logic      o_busy,
   output logic      o_done_tick
);

   localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
   localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

   localparam logic [SW-1:0] S_BIT_LAST  = SW'(15);
   localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
   localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t          r_state, w_state_next;
   logic [SW-1:0]   r_s, w_s_next;
   logic [NW-1:0]   r_n, w_n_next;
   logic [DBIT-1:0] r_b, w_b_next;
   logic            r_par, w_par_next;
   logic            r_par_en, w_par_en_next;
   logic            r_par_odd, w_par_odd_next;
   logic            r_tx, w_tx_next;
   logic            w_rd;
   logic            w_done;

   // Next-state and counter logic
   always_comb begin
      w_state_next   = r_state;
      w_s_next       = r_s;
      w_n_next       = r_n;
      w_b_next       = r_b;
      w_par_next     = r_par;
      w_par_en_next  = r_par_en;
      w_par_odd_next = r_par_odd;
      w_rd           = 1'b0;
      w_done         = 1'b0;

      case (r_state)
         IDLE: begin
            // FWFT FIFO: the head word is captured in the same cycle as the pop
            if (!fifo.i_empty) begin
               w_rd           = 1'b1;
               w_b_next       = fifo.i_rd_data;
               w_par_en_next  = i_parity_en;
               w_par_odd_next = i_parity_odd;
               w_par_next     = 1'b0;
               w_s_next       = '0;
               w_state_next   = START;
            end
         end
         START: begin
            if (i_s_tick) begin
               if (r_s == S_BIT_LAST) begin
                  w_s_next     = '0;
                  w_n_next     = '0;
                  w_state_next = DATA;
               end else begin
                  w_s_next = r_s + 1'b1;
               end
            end
         end
         DATA: begin
            if (i_s_tick) begin
               if (r_s == S_BIT_LAST) begin
                  w_par_next = r_par ^ r_b[0];
                  w_b_next   = r_b >> 1;
                  w_s_next   = '0;
                  if (r_n == N_LAST) begin
                     w_state_next = r_par_en ? PARITY : STOP;
                  end else begin
                     w_n_next = r_n + 1'b1;
                  end
               end else begin
                  w_s_next = r_s + 1'b1;
               end
            end
         end
         PARITY: begin
            if (i_s_tick) begin
               if (r_s == S_BIT_LAST) begin
                  w_s_next     = '0;
                  w_state_next = STOP;
               end else begin
                  w_s_next = r_s + 1'b1;
               end
            end
         end
         STOP: begin
            if (i_s_tick) begin
               if (r_s == S_STOP_LAST) begin
                  w_done       = 1'b1;
                  w_s_next     = '0;
                  w_state_next = IDLE;
               end else begin
                  w_s_next = r_s + 1'b1;
               end
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // Line level derived from the next state so o_tx moves on the same edge
   // as the state/bit change.
   always_comb begin
      w_tx_next = 1'b1;
      case (w_state_next)
         IDLE:    w_tx_next = 1'b1;
         START:   w_tx_next = 1'b0;
         DATA:    w_tx_next = w_b_next[0];
         PARITY:  w_tx_next = w_par_next ^ w_par_odd_next;
         STOP:    w_tx_next = 1'b1;
         default: w_tx_next = 1'b1;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state   <= IDLE;
         r_s       <= '0;
         r_n       <= '0;
         r_b       <= '0;
         r_par     <= 1'b0;
         r_par_en  <= 1'b0;
         r_par_odd <= 1'b0;
         r_tx      <= 1'b1;
      end else begin
         r_state   <= w_state_next;
         r_s       <= w_s_next;
         r_n       <= w_n_next;
         r_b       <= w_b_next;
         r_par     <= w_par_next;
         r_par_en  <= w_par_en_next;
         r_par_odd <= w_par_odd_next;
         r_tx      <= w_tx_next;
      end
   end

   // Strobes are suppressed while reset is asserted so a popped word is never
   // lost to a reset edge and no completion is reported for an aborted frame.
   assign fifo.o_rd   = w_rd & ~i_reset;
   assign o_done_tick = w_done & ~i_reset;
   assign o_busy      = (r_state != IDLE);
   assign o_tx        = r_tx;

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx : self-checking bench for uart_tx.
//   Two instances: SB_TICK=16 (channel 0) and SB_TICK=32 (channel 1), each
//   fed by a bench FIFO queue. A tick-position model predicts the line,
//   busy, pop strobe and done pulse every cycle; directed tests add literal
//   expectations for frame contents and lengths.
// ---------------------------------------------------------------------------
module tb_uart_tx;

   localparam int DBIT = 8;
   localparam int SB0  = 16;
   localparam int SB1  = 32;

   logic clk = 1'b0;
   logic rst;
   logic s_tick;
   logic pe;
   logic po;
   logic tx0, busy0, done0;
   logic tx1, busy1, done1;

   uart_tx_if #(.DBIT(DBIT)) if0 ();
   uart_tx_if #(.DBIT(DBIT)) if1 ();

   uart_tx #(.DBIT(DBIT), .SB_TICK(SB0)) u_dut0 (
      .i_clk        (clk),
      .i_reset      (rst),
      .i_s_tick     (s_tick),
      .fifo         (if0.slave),
      .i_parity_en  (pe),
      .i_parity_odd (po),
      .o_tx         (tx0),
      .o_busy       (busy0),
      .o_done_tick  (done0)
   );

   uart_tx #(.DBIT(DBIT), .SB_TICK(SB1)) u_dut1 (
      .i_clk        (clk),
      .i_reset      (rst),
      .i_s_tick     (s_tick),
      .fifo         (if1.slave),
      .i_parity_en  (pe),
      .i_parity_odd (po),
      .o_tx         (tx1),
      .o_busy       (busy1),
      .o_done_tick  (done1)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int rd_cnt0  = 0;

   logic [7:0] q0[$];
   logic [7:0] q1[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic fifo_refresh();
      if0.i_empty   = (q0.size() == 0);
      if0.i_rd_data = (q0.size() != 0) ? q0[0] : '0;
      if1.i_empty   = (q1.size() == 0);
      if1.i_rd_data = (q1.size() != 0) ? q1[0] : '0;
   endtask

   task automatic push_now(input int ch, input logic [7:0] b);
      if (ch == 0) q0.push_back(b);
      else         q1.push_back(b);
      fifo_refresh();
   endtask

   function automatic logic get_tx(input int ch);
      return (ch == 0) ? tx0 : tx1;
   endfunction
   function automatic logic get_rd(input int ch);
      return (ch == 0) ? if0.o_rd : if1.o_rd;
   endfunction
   function automatic logic get_done(input int ch);
      return (ch == 0) ? done0 : done1;
   endfunction

   // Frame model: position in ticks since the pop, segments of 16 ticks.
   typedef struct packed {
      logic        active;
      int          t;
      int          total;
      int          nseg;
      logic [10:0] seg;
      logic        line;
   } mdl_t;

   function automatic mdl_t mdl_step(input mdl_t m, input logic r, input logic tk,
                                     input logic ne, input logic [7:0] head,
                                     input logic cpe, input logic cpo, input int sb);
      mdl_t n = m;
      if (r) begin
         n.active = 1'b0;
         n.line   = 1'b1;
      end else if (!m.active) begin
         if (ne) begin
            n.active = 1'b1;
            n.t      = 0;
            n.nseg   = 9 + (cpe ? 1 : 0);
            n.seg    = {1'b1, (cpe ? ((^head) ^ cpo) : 1'b1), head, 1'b0};
            n.total  = n.nseg * 16 + sb;
            n.line   = 1'b0;
         end
      end else if (tk) begin
         n.t = m.t + 1;
         if (n.t == n.total) begin
            n.active = 1'b0;
            n.line   = 1'b1;
         end else begin
            n.line = (n.t / 16 < n.nseg) ? n.seg[n.t / 16] : 1'b1;
         end
      end
      return n;
   endfunction

   mdl_t m0, m1;

   // Per-cycle compare of both channels against the model
   initial begin
      logic pop0, pop1, er0, er1, ed0, ed1;
      m0 = '0; m0.line = 1'b1;
      m1 = '0; m1.line = 1'b1;
      @(posedge clk); #1;
      forever begin
         @(negedge clk);
         er0 = !rst && !m0.active && !if0.i_empty;
         ed0 = !rst && m0.active && s_tick && (m0.t == m0.total - 1);
         er1 = !rst && !m1.active && !if1.i_empty;
         ed1 = !rst && m1.active && s_tick && (m1.t == m1.total - 1);
         chk("m0_tx",   tx0,      m0.line);
         chk("m0_busy", busy0,    m0.active);
         chk("m0_rd",   if0.o_rd, er0);
         chk("m0_done", done0,    ed0);
         chk("m1_tx",   tx1,      m1.line);
         chk("m1_busy", busy1,    m1.active);
         chk("m1_rd",   if1.o_rd, er1);
         chk("m1_done", done1,    ed1);
         pop0 = if0.o_rd;
         pop1 = if1.o_rd;
         if (pop0) rd_cnt0++;
         m0 = mdl_step(m0, rst, s_tick, !if0.i_empty, if0.i_rd_data, pe, po, SB0);
         m1 = mdl_step(m1, rst, s_tick, !if1.i_empty, if1.i_rd_data, pe, po, SB1);
         @(posedge clk); #1;
         if (pop0 && q0.size() > 0) void'(q0.pop_front());
         if (pop1 && q1.size() > 0) void'(q1.pop_front());
         fifo_refresh();
      end
   end

   // Oversampling tick: one clock in four
   initial begin
      int tcnt = 0;
      s_tick = 1'b0;
      forever begin
         @(posedge clk); #1;
         tcnt++;
         s_tick = (tcnt % 4 == 0);
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic at_edge();
      @(posedge clk); #1;
   endtask

   task automatic wait_rd(input int ch, input string nm);
      logic got = 1'b0;
      for (int c = 0; c < 3000 && !got; c++) begin
         @(negedge clk);
         if (get_rd(ch)) got = 1'b1;
      end
      chk(nm, got, 1'b1);
   endtask

   task automatic check_next_rd(input int ch, input string nm);
      @(negedge clk);
      chk(nm, get_rd(ch), 1'b1);
   endtask

   // Starts on the cycle after the pop; samples the line mid-segment and
   // counts ticks up to and including the done pulse.
   task automatic sample_frame(input int ch, output logic [10:0] segs,
                               output int nt, output int nrd);
      int   k    = 0;
      logic seen = 1'b0;
      segs = '1;
      nrd  = 0;
      for (int c = 0; c < 4000 && !seen; c++) begin
         @(negedge clk);
         if (k % 16 == 8 && k / 16 < 11) segs[k / 16] = get_tx(ch);
         if (get_rd(ch)) nrd++;
         if (get_done(ch)) seen = 1'b1;
         if (s_tick) k++;
      end
      nt = seen ? k : -1;
   endtask

   initial begin
      logic [10:0] segs;
      int          nt, nrd, base, k;

      rst = 1'b1; pe = 1'b0; po = 1'b0;
      q0.push_back(8'h55);
      fifo_refresh();

      // Reset with a word waiting
      @(posedge clk);
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("t1_tx_in_reset", tx0, 1'b1);
         chk("t1_rd_in_reset", if0.o_rd, 1'b0);
      end
      at_edge();
      rst = 1'b0;
      check_next_rd(0, "t1_rd_first");
      sample_frame(0, segs, nt, nrd);
      chk("t1_segs", {22'd0, segs[9:0]}, 32'h2AA);
      chk("t1_ticks", nt, 160);
      chk("t1_rd_once", nrd, 0);

      // Even then odd parity
      at_edge();
      pe = 1'b1; po = 1'b0;
      push_now(0, 8'hA3);
      push_now(0, 8'h07);
      wait_rd(0, "t2_rd_a3");
      sample_frame(0, segs, nt, nrd);
      chk("t2_even_a3_par", segs[9], 1'b0);
      chk("t2_even_a3_data", segs[8:1], 8'hA3);
      chk("t2_even_a3_ticks", nt, 176);
      check_next_rd(0, "t2_rd_07");
      sample_frame(0, segs, nt, nrd);
      chk("t2_even_07_par", segs[9], 1'b1);
      chk("t2_even_07_ticks", nt, 176);
      at_edge();
      po = 1'b1;
      push_now(0, 8'hA3);
      push_now(0, 8'h07);
      wait_rd(0, "t2_rd_a3_odd");
      sample_frame(0, segs, nt, nrd);
      chk("t2_odd_a3_par", segs[9], 1'b1);
      check_next_rd(0, "t2_rd_07_odd");
      sample_frame(0, segs, nt, nrd);
      chk("t2_odd_07_par", segs[9], 1'b0);
      chk("t2_odd_07_stop", segs[10], 1'b1);

      // Back-to-back bytes
      at_edge();
      pe = 1'b0; po = 1'b0;
      base = rd_cnt0;
      push_now(0, 8'h01);
      push_now(0, 8'h80);
      push_now(0, 8'hFF);
      wait_rd(0, "t3_rd_01");
      sample_frame(0, segs, nt, nrd);
      chk("t3_data_01", segs[9:0], 10'h202);
      check_next_rd(0, "t3_rd_80");
      sample_frame(0, segs, nt, nrd);
      chk("t3_data_80", segs[9:0], 10'h300);
      check_next_rd(0, "t3_rd_ff");
      sample_frame(0, segs, nt, nrd);
      chk("t3_data_ff", segs[9:0], 10'h3FE);
      repeat (20) @(negedge clk);
      chk("t3_rd_pulses", rd_cnt0 - base, 3);

      // Reset in the middle of data bit 3 of 0x3C
      at_edge();
      push_now(0, 8'h3C);
      push_now(0, 8'h11);
      wait_rd(0, "t4_rd_3c");
      k = 0;
      for (int c = 0; c < 1000 && k < 72; c++) begin
         @(negedge clk);
         if (s_tick) k++;
      end
      chk("t4_reach_bit3", k, 72);
      chk("t4_bit3_level", tx0, 1'b1);
      at_edge();
      rst = 1'b1;
      @(negedge clk);
      chk("t4_rd_in_reset", if0.o_rd, 1'b0);
      chk("t4_done_in_reset", done0, 1'b0);
      at_edge();
      rst = 1'b0;
      @(negedge clk);
      chk("t4_tx_after_reset", tx0, 1'b1);
      chk("t4_busy_after_reset", busy0, 1'b0);
      chk("t4_rd_next", if0.o_rd, 1'b1);
      sample_frame(0, segs, nt, nrd);
      chk("t4_clean_frame", segs[9:0], 10'h222);
      chk("t4_clean_ticks", nt, 160);

      // SB_TICK=32 with parity enable toggled mid-frame
      at_edge();
      pe = 1'b0; po = 1'b0;
      push_now(1, 8'h5A);
      wait_rd(1, "t5_rd_a");
      fork
         sample_frame(1, segs, nt, nrd);
         begin
            repeat (200) @(posedge clk);
            #1 pe = 1'b1;
         end
      join
      chk("t5_a_ticks", nt, 176);
      chk("t5_a_no_par", segs[9], 1'b1);
      chk("t5_a_data", segs[8:1], 8'h5A);
      at_edge();
      push_now(1, 8'h5A);
      wait_rd(1, "t5_rd_b");
      fork
         sample_frame(1, segs, nt, nrd);
         begin
            repeat (200) @(posedge clk);
            #1 pe = 1'b0;
         end
      join
      chk("t5_b_ticks", nt, 192);
      chk("t5_b_par", segs[9], 1'b0);
      chk("t5_b_stop", segs[10], 1'b1);

      repeat (10) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
